note_lane_engine: RTL and testbench

Parametrised rhythm-game note engine for the DE1_SoC LED-matrix game. It is the multi-lane successor of the fixed 4-column/8-row logic and generalises lane count, lane depth and score range. It adds a tunable spawn density, forced spawns, note spacing, false-press penalties, saturating per-lane scores and a global combo counter. It sits between the key conditioning stage (double DFF plus one-pulse) and the LED driver / HEX score display.

---
 rtl/note_lane_engine.sv | 151 +++++++++++++++
 tb/tb_note_lane_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_engine.sv
// note_lane_engine: multi-lane rhythm-game note engine.
// Notes spawn at the top row of each lane, step down one row per tick, and are scored
// when a key pulse meets a note in the hit row (row 0).
//
// Ports:
//   clk_i           system clock, all state on posedge
//   rst_ni          synchronous active-low reset
//   enable_i        1 = run, 0 = freeze all state (pulses forced low)
//   tick_i          single-cycle note-step strobe
//   key_i           per-lane single-cycle press pulses (already synchronised)
//   spawn_req_i     per-lane forced spawn, sampled on tick cycles only
//   spawn_thresh_i  random spawn density (0 = never, >= 128 = always)
//   lane_pix_o      note map, lane l row r at bit l*DEPTH+r
//   score_o         per-lane saturating score, lane l at [l*SCORE_W +: SCORE_W]
//   combo_o         consecutive-hit counter
//   hit_pulse_o     one-cycle pulse per hit
//   miss_pulse_o    one-cycle pulse per fall-off or false press
module note_lane_engine #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_SCORE = 9,
    parameter int unsigned SCORE_W   = 4,
    parameter int unsigned COMBO_W   = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       tick_i,
    input  logic [LANES-1:0]           key_i,
    input  logic [LANES-1:0]           spawn_req_i,
    input  logic [7:0]                 spawn_thresh_i,
    output logic [LANES*DEPTH-1:0]     lane_pix_o,
    output logic [LANES*SCORE_W-1:0]   score_o,
    output logic [COMBO_W-1:0]         combo_o,
    output logic [LANES-1:0]           hit_pulse_o,
    output logic [LANES-1:0]           miss_pulse_o
);

    // An all-zero seed would lock the LFSR.
    localparam logic [15:0] SeedEff  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int unsigned ComboMax = (1 << COMBO_W) - 1;

    logic [LANES*DEPTH-1:0]   pix_q, pix_d;
    logic [LANES*SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0]       combo_q, combo_d;
    logic [LANES-1:0]         hit_q, hit_d;
    logic [LANES-1:0]         miss_q, miss_d;
    logic [15:0]              lfsr_q, lfsr_d;

    // Lane random value: LFSR rotated right by 3*l, low 7 bits.
    function automatic logic [6:0] lane_rand(input logic [15:0] v, input int unsigned l);
        logic [31:0] dbl;
        int unsigned sh;
        sh  = (3 * l) % 16;
        dbl = {v, v} >> sh;
        return dbl[6:0];
    endfunction

    always_comb begin
        logic                row0;
        logic                top;
        logic                spawn;
        logic                hit;
        logic                miss;
        logic [SCORE_W-1:0]  s;
        int unsigned         nhits;
        int unsigned         csum;

        lfsr_d  = lfsr_q;
        pix_d   = pix_q;
        score_d = score_q;
        combo_d = combo_q;
        hit_d   = '0;
        miss_d  = '0;
        row0    = 1'b0;
        top     = 1'b0;
        spawn   = 1'b0;
        hit     = 1'b0;
        miss    = 1'b0;
        s       = '0;
        nhits   = 0;
        csum    = 0;

        if (enable_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

            for (int unsigned l = 0; l < LANES; l++) begin
                // All decisions use the pre-shift note map.
                row0  = pix_q[l*DEPTH];
                top   = pix_q[l*DEPTH + DEPTH - 1];
                spawn = (spawn_req_i[l] | ({1'b0, lane_rand(lfsr_q, l)} < spawn_thresh_i))
                        & ~top;
                hit   = key_i[l] & row0;
                // False press and fall-off cannot both happen: one needs key, the other !key.
                miss  = (key_i[l] & ~row0) | (tick_i & row0 & ~key_i[l]);

                hit_d[l]  = hit;
                miss_d[l] = miss;
                nhits     = nhits + {31'd0, hit};

                s = score_q[l*SCORE_W +: SCORE_W];
                if (hit && (32'(s) < MAX_SCORE)) begin
                    s = s + SCORE_W'(1);
                end else if (miss && (s != '0)) begin
                    s = s - SCORE_W'(1);
                end
                score_d[l*SCORE_W +: SCORE_W] = s;

                if (tick_i) begin
                    pix_d[l*DEPTH +: DEPTH] = {spawn, pix_q[l*DEPTH+1 +: DEPTH-1]};
                end else if (hit) begin
                    pix_d[l*DEPTH] = 1'b0;
                end
            end

            // Any miss clears the combo, even if another lane hit this cycle.
            if (|miss_d) begin
                combo_d = '0;
            end else begin
                csum    = 32'(combo_q) + nhits;
                combo_d = (csum > ComboMax) ? COMBO_W'(ComboMax) : COMBO_W'(csum);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pix_q   <= '0;
            score_q <= '0;
            combo_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            lfsr_q  <= SeedEff;
        end else begin
            pix_q   <= pix_d;
            score_q <= score_d;
            combo_q <= combo_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign lane_pix_o   = pix_q;
    assign score_o      = score_q;
    assign combo_o      = combo_q;
    assign hit_pulse_o  = hit_q;
    assign miss_pulse_o = miss_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Scoreboard bench for note_lane_engine (LANES=4, DEPTH=8, MAX_SCORE=9).
// The driver queues hand-computed expectations tagged with the cycle they become visible;
// a monitor on the falling edge pops and compares them.
module tb_note_lane_engine;

    localparam int PIX   = 0;
    localparam int SCORE = 1;
    localparam int COMBO = 2;
    localparam int HIT   = 3;
    localparam int MISS  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        tick;
    logic [3:0]  key;
    logic [3:0]  spawn_req;
    logic [7:0]  spawn_thresh;
    logic [31:0] lane_pix;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [3:0]  hit_pulse;
    logic [3:0]  miss_pulse;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    note_lane_engine dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .tick_i         (tick),
        .key_i          (key),
        .spawn_req_i    (spawn_req),
        .spawn_thresh_i (spawn_thresh),
        .lane_pix_o     (lane_pix),
        .score_o        (score),
        .combo_o        (combo),
        .hit_pulse_o    (hit_pulse),
        .miss_pulse_o   (miss_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int f);
        case (f)
            PIX:     return lane_pix;
            SCORE:   return {16'd0, score};
            COMBO:   return {24'd0, combo};
            HIT:     return {28'd0, hit_pulse};
            default: return {28'd0, miss_pulse};
        endcase
    endfunction

    // Monitor: compare every expectation that is due at this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            checks++;
            if (cur.cyc < cyc) begin
                errors++;
                $display("FAIL %s: stale expectation for cycle %0d at cycle %0d",
                         cur.name, cur.cyc, cyc);
            end else if (actual(cur.fld) !== cur.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)",
                         cur.name, actual(cur.fld), cur.val, cyc);
            end
        end
    end

    // Expectation for the outputs visible after the next rising edge.
    task automatic ex(input int f, input logic [31:0] v, input string n);
        exp_q.push_back('{cyc + 1, f, v, n});
    endtask

    task automatic ex_all(input logic [31:0] p, input logic [15:0] s, input logic [7:0] c,
                          input logic [3:0] h, input logic [3:0] m, input string n);
        ex(PIX, p, {n, "_pix"});
        ex(SCORE, {16'd0, s}, {n, "_score"});
        ex(COMBO, {24'd0, c}, {n, "_combo"});
        ex(HIT, {28'd0, h}, {n, "_hit"});
        ex(MISS, {28'd0, m}, {n, "_miss"});
    endtask

    // One clock of stimulus, driven just after a falling edge.
    task automatic step(input logic en, input logic tk, input logic [3:0] k,
                        input logic [3:0] rq);
        enable    = en;
        tick      = tk;
        key       = k;
        spawn_req = rq;
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        tick         = 1'b0;
        key          = '0;
        spawn_req    = '0;
        spawn_thresh = 8'd0;
        @(negedge clk);

        // Reset has priority over tick/key/spawn.
        step(1'b1, 1'b1, 4'hF, 4'hF);
        ex_all(32'h0, 16'h0, 8'd0, 4'h0, 4'h0, "reset");
        step(1'b1, 1'b1, 4'hF, 4'hF);
        rst_n = 1'b1;

        // Hit path: forced spawn, walk to row 0, hit.
        ex(PIX, 32'h0000_0080, "spawn_row7");
        step(1'b1, 1'b1, 4'h0, 4'h1);
        repeat (6) step(1'b1, 1'b1, 4'h0, 4'h0);
        ex(PIX, 32'h0000_0001, "note_row0");
        step(1'b1, 1'b1, 4'h0, 4'h0);
        ex_all(32'h0, 16'h0001, 8'd1, 4'h1, 4'h0, "hit");
        step(1'b1, 1'b0, 4'h1, 4'h0);
        ex(HIT, 32'h0, "hit_one_cycle");
        ex(COMBO, 32'd1, "combo_hold");
        step(1'b1, 1'b0, 4'h0, 4'h0);

        // Second hit to reach score 2.
        step(1'b1, 1'b1, 4'h0, 4'h1);
        repeat (7) step(1'b1, 1'b1, 4'h0, 4'h0);
        ex(SCORE, 32'h0002, "hit2_score");
        ex(COMBO, 32'd2, "hit2_combo");
        step(1'b1, 1'b0, 4'h1, 4'h0);

        // Fall-off, then false presses down to the floor.
        step(1'b1, 1'b1, 4'h0, 4'h1);
        repeat (7) step(1'b1, 1'b1, 4'h0, 4'h0);
        ex_all(32'h0, 16'h0001, 8'd0, 4'h0, 4'h1, "falloff");
        step(1'b1, 1'b1, 4'h0, 4'h0);
        ex(SCORE, 32'h0000, "false1_score");
        ex(MISS, 32'h1, "false1_miss");
        step(1'b1, 1'b0, 4'h1, 4'h0);
        ex(SCORE, 32'h0000, "false2_floor");
        ex(MISS, 32'h1, "false2_miss");
        step(1'b1, 1'b0, 4'h1, 4'h0);
        ex(MISS, 32'h0, "miss_one_cycle");
        step(1'b1, 1'b0, 4'h0, 4'h0);

        // Key together with tick; notes two rows apart (spawn spacing).
        step(1'b1, 1'b1, 4'h0, 4'h1);
        step(1'b1, 1'b1, 4'h0, 4'h1);  // blocked: row 7 occupied
        ex(PIX, 32'h0000_00A0, "spacing");
        step(1'b1, 1'b1, 4'h0, 4'h1);
        repeat (4) step(1'b1, 1'b1, 4'h0, 4'h0);
        ex(PIX, 32'h0000_0005, "rows_0_2");
        step(1'b1, 1'b1, 4'h0, 4'h0);
        ex_all(32'h0000_0002, 16'h0001, 8'd1, 4'h1, 4'h0, "keytick_hit");
        step(1'b1, 1'b1, 4'h1, 4'h0);
        ex_all(32'h0000_0001, 16'h0000, 8'd0, 4'h0, 4'h1, "keytick_false");
        step(1'b1, 1'b1, 4'h1, 4'h0);
        ex(PIX, 32'h0, "last_falloff_pix");
        ex(MISS, 32'h1, "last_falloff_miss");
        step(1'b1, 1'b1, 4'h0, 4'h0);

        // Stream of 12 notes in lane 0, each hit: score saturates at 9, combo reaches 12.
        for (int t = 1; t <= 31; t++) begin
            if (t == 10) begin
                ex(HIT, 32'h0, "stream_gap_hit");
                ex(COMBO, 32'd1, "stream_gap_combo");
            end
            if (t == 25) begin
                ex(SCORE, 32'h0009, "sat_score9");
                ex(COMBO, 32'd9, "sat_combo9");
            end
            if (t == 26) ex(MISS, 32'h0, "stream_no_miss");
            if (t == 27) begin
                ex(SCORE, 32'h0009, "sat_hold");
                ex(COMBO, 32'd10, "sat_combo10");
            end
            if (t == 31) ex_all(32'h0, 16'h0009, 8'd12, 4'h1, 4'h0, "stream_end");
            step(1'b1, 1'b1, ((t >= 9) && (t % 2 == 1)) ? 4'h1 : 4'h0,
                 (t <= 23) ? 4'h1 : 4'h0);
        end

        // Always-spawn density: alternating pattern in every lane.
        spawn_thresh = 8'd128;
        repeat (6) step(1'b1, 1'b1, 4'h0, 4'h0);
        ex(PIX, 32'hAAAA_AAAA, "dense_7ticks");
        step(1'b1, 1'b1, 4'h0, 4'h0);
        ex(PIX, 32'h5555_5555, "dense_8ticks");
        ex(COMBO, 32'd12, "dense_combo");
        step(1'b1, 1'b1, 4'h0, 4'h0);
        spawn_thresh = 8'd0;

        // Freeze with notes present: nothing moves, no pulses.
        for (int i = 1; i <= 5; i++) begin
            if (i == 1 || i == 5) ex_all(32'h5555_5555, 16'h0009, 8'd12, 4'h0, 4'h0, "freeze");
            step(1'b0, 1'b1, 4'hF, 4'hF);
        end
        // Resume: two lanes hit at once, combo adds both.
        ex_all(32'h5555_5454, 16'h0019, 8'd14, 4'h3, 4'h0, "resume");
        step(1'b1, 1'b0, 4'h3, 4'h0);

        // Mid-game reset, then frozen cycles, then LFSR-driven spawns from the seed.
        rst_n = 1'b0;
        ex_all(32'h0, 16'h0, 8'd0, 4'h0, 4'h0, "reset2a");
        step(1'b1, 1'b1, 4'hF, 4'hF);
        ex_all(32'h0, 16'h0, 8'd0, 4'h0, 4'h0, "reset2b");
        step(1'b1, 1'b1, 4'hF, 4'hF);
        rst_n = 1'b1;
        spawn_thresh = 8'd60;
        repeat (4) step(1'b0, 1'b1, 4'hF, 4'hF);
        ex_all(32'h0, 16'h0, 8'd0, 4'h0, 4'h0, "freeze_after_reset");
        step(1'b0, 1'b1, 4'hF, 4'hF);
        // Seed ACE1 gives lane values 97, 28, 51, 86: lanes 1 and 2 spawn.
        ex(PIX, 32'h0080_8000, "lfsr_seed_spawn");
        step(1'b1, 1'b1, 4'h0, 4'h0);
        // Next state 59C3 gives 67, 56, 103, 44: lane 1 blocked by spacing, lane 3 spawns.
        ex(PIX, 32'h8040_4000, "lfsr_step_spawn");
        step(1'b1, 1'b1, 4'h0, 4'h0);
        step(1'b1, 1'b0, 4'h0, 4'h0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
